// File: rtl/matmul_pkg.sv
// Shared types and the output scale/saturate helper for the streaming matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Widest accumulator the helper accepts; callers sign-extend into this.
    localparam int MAX_W = 128;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } scaled_t;

    // Floor-shift an accumulator by frac, then either clamp it to the signed
    // width-bit range or leave it for the caller to truncate (wrap). ovf is
    // raised whenever the shifted value does not fit in width bits.
    function automatic scaled_t scale_sat(input logic signed [MAX_W-1:0] acc,
                                          input int width,
                                          input int frac,
                                          input bit saturate);
        scaled_t                 res;
        logic signed [MAX_W-1:0] r;
        logic signed [MAX_W-1:0] lo;
        logic signed [MAX_W-1:0] hi;
        r       = acc >>> frac;
        lo      = '1;
        lo      = lo <<< (width - 1);
        hi      = ~lo;
        res.ovf = (r > hi) || (r < lo);
        if (saturate && (r > hi)) begin
            res.val = hi;
        end else if (saturate && (r < lo)) begin
            res.val = lo;
        end else begin
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One signed multiply-accumulate cell: clear has priority over enable.
module mac_pe
    import matmul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    // Accumulate the sign-extended full product; a narrow ACC_W simply wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/matmul_stream.sv
// Streaming N x N signed matrix multiplier: accept A/B, run N parallel MAC
// steps, then one finalise cycle that scales/saturates into the output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid and its payload must stay put until that edge, and ready may
// depend combinationally only on state and reset, never on valid.
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 16,
    parameter int ACC_W    = 2*WIDTH + $clog2(N),
    parameter int FRAC     = 0,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N*N*WIDTH-1:0]    a_flat,
    input  logic [N*N*WIDTH-1:0]    b_flat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N*N*WIDTH-1:0]    c_flat,
    output logic                    ovf,
    output logic [1:0]              dbg_state
);

    // k runs 0..N: N accumulate steps, and k==N marks the finalise cycle.
    localparam int KW = $clog2(N + 1);
    localparam int KI = $clog2(N);

    state_t                  state;
    state_t                  state_nxt;
    logic [KW-1:0]           k;
    logic [KI-1:0]           k_idx;
    logic [N*N*WIDTH-1:0]    a_q;
    logic [N*N*WIDTH-1:0]    b_q;
    logic                    accept;
    logic                    pe_en;
    logic                    finalise;
    logic                    release_out;
    logic [N*N*WIDTH-1:0]    c_next;
    logic [N*N-1:0]          ovf_vec;
    logic [N*N-1:0]          unused_hi;

    logic signed [WIDTH-1:0] a_m   [N][N];
    logic signed [WIDTH-1:0] b_m   [N][N];
    logic signed [ACC_W-1:0] acc_m [N][N];

    assign k_idx     = k[KI-1:0];
    assign dbg_state = state;

    // State register; reset abandons any operand pair in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, leave COMPUTE after the finalise cycle, drain in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept)      state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (finalise)    state_nxt = ST_DONE;
            ST_DONE:    if (release_out) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode; s_ready stays low while reset is asserted.
    always_comb begin
        s_ready     = 1'b0;
        pe_en       = 1'b0;
        finalise    = 1'b0;
        release_out = 1'b0;
        case (state)
            ST_IDLE:    s_ready     = !rst;
            ST_COMPUTE: begin
                pe_en    = (k != KW'(N));
                finalise = (k == KW'(N));
            end
            ST_DONE:    release_out = m_ready;
            default:    ;
        endcase
        accept = s_valid && s_ready;
    end

    // Operand capture, step counter and the registered result/handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            k       <= '0;
            c_flat  <= '0;
            ovf     <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a_flat;
                b_q <= b_flat;
                k   <= '0;
            end
            if (pe_en) begin
                k <= k + KW'(1);
            end
            if (finalise) begin
                c_flat  <= c_next;
                ovf     <= |ovf_vec;
                m_valid <= 1'b1;
            end
            if (release_out) begin
                m_valid <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            scaled_t sc;

            assign a_m[gi][gj] = a_q[(gi*N + gj)*WIDTH +: WIDTH];
            assign b_m[gi][gj] = b_q[(gi*N + gj)*WIDTH +: WIDTH];

            mac_pe #(
                .WIDTH (WIDTH),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk (clk),
                .rst (rst),
                .clr (accept),
                .en  (pe_en),
                .a   (a_m[gi][k_idx]),
                .b   (b_m[k_idx][gj]),
                .acc (acc_m[gi][gj])
            );

            assign sc = scale_sat({{(MAX_W-ACC_W){acc_m[gi][gj][ACC_W-1]}}, acc_m[gi][gj]},
                                  WIDTH, FRAC, SATURATE != 0);
            assign c_next[(gi*N + gj)*WIDTH +: WIDTH] = sc.val[WIDTH-1:0];
            assign ovf_vec[gi*N + gj]                 = sc.ovf;
            // Upper bits are already folded into sc.ovf.
            assign unused_hi[gi*N + gj]               = ^sc.val[MAX_W-1:WIDTH];
        end
    end

endmodule

// File: tb/tb_matmul_stream.sv
// Bench for matmul_stream with three N=2, WIDTH=8 instances:
// 0 = saturate, 1 = wrap, 2 = saturate with FRAC=4.
module tb_matmul_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid [3];
    logic        s_ready [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic        ovf     [3];
    logic [31:0] a_flat  [3];
    logic [31:0] b_flat  [3];
    logic [31:0] c_flat  [3];
    logic [1:0]  dbg     [3];

    logic [32:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    matmul_stream #(.N(2), .WIDTH(8), .FRAC(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .a_flat(a_flat[0]), .b_flat(b_flat[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .c_flat(c_flat[0]), .ovf(ovf[0]), .dbg_state(dbg[0]));

    matmul_stream #(.N(2), .WIDTH(8), .FRAC(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .a_flat(a_flat[1]), .b_flat(b_flat[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .c_flat(c_flat[1]), .ovf(ovf[1]), .dbg_state(dbg[1]));

    matmul_stream #(.N(2), .WIDTH(8), .FRAC(4), .SATURATE(1)) u_frac (
        .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .a_flat(a_flat[2]), .b_flat(b_flat[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready[2]), .c_flat(c_flat[2]), .ovf(ovf[2]), .dbg_state(dbg[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int e00, input int e01, input int e10, input int e11);
        return {e11[7:0], e10[7:0], e01[7:0], e00[7:0]};
    endfunction

    // Reference: integer matrix product, floor shift, clamp or wrap; bit 32 = ovf.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int frac, input bit sat);
        logic [31:0] c;
        logic        o;
        logic [7:0]  ea;
        logic [7:0]  eb;
        int          s;
        c = '0;
        o = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int kk = 0; kk < 2; kk++) begin
                    ea = a[(i*2 + kk)*8 +: 8];
                    eb = b[(kk*2 + j)*8 +: 8];
                    s  = s + int'($signed(ea)) * int'($signed(eb));
                end
                s = s >>> frac;
                if (s > 127 || s < -128) o = 1'b1;
                if (sat && s > 127)  s = 127;
                if (sat && s < -128) s = -128;
                c[(i*2 + j)*8 +: 8] = s[7:0];
            end
        end
        return {o, c};
    endfunction

    function automatic int frac_of(input int d);
        return (d == 2) ? 4 : 0;
    endfunction

    function automatic bit sat_of(input int d);
        return d != 1;
    endfunction

    // Present one operand pair, wait (bounded) for acceptance, queue its expected result.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
        int guard;
        guard     = 0;
        s_valid[d] = 1'b1;
        a_flat[d]  = a;
        b_flat[d]  = b;
        while (!s_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("s_ready_timeout", 64'(s_ready[d]), 64'd1);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        s_valid[d] = 1'b0;
        a_flat[d]  = $urandom();
        b_flat[d]  = $urandom();
    endtask

    // Wait (bounded) for the result, compare against the queue head, optionally
    // hold m_ready low for `hold` cycles, then accept it.
    task automatic recv(input int d, input bit chk_lat, input int hold);
        int          lat;
        logic [32:0] exp;
        lat = 0;
        while (!m_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("m_valid_seen", 64'(m_valid[d]), 64'd1);
        if (chk_lat) check("latency", 64'(lat), 64'd3);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check("c_flat", 64'(c_flat[d]), 64'(exp[31:0]));
            check("ovf", 64'(ovf[d]), 64'(exp[32]));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_c_flat", 64'(c_flat[d]), 64'(exp[31:0]));
                check("hold_m_valid", 64'(m_valid[d]), 64'd1);
                check("hold_s_ready", 64'(s_ready[d]), 64'd0);
            end
        end
        m_ready[d] = 1'b1;
        @(negedge clk);
        m_ready[d] = 1'b0;
        check("m_valid_drop", 64'(m_valid[d]), 64'd0);
        check("s_ready_back", 64'(s_ready[d]), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        for (int d = 0; d < 3; d++) begin
            s_valid[d] = 1'b0;
            m_ready[d] = 1'b0;
            a_flat[d]  = '0;
            b_flat[d]  = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_s_ready", 64'(s_ready[d]), 64'd0);
            check("rst_m_valid", 64'(m_valid[d]), 64'd0);
            check("rst_c_flat", 64'(c_flat[d]), 64'd0);
            check("rst_ovf", 64'(ovf[d]), 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("post_rst_s_ready", 64'(s_ready[d]), 64'd1);
        @(negedge clk);

        // Identity times B, with latency check
        send(0, pack(1, 0, 0, 1), pack(1, 2, 3, 4), {1'b0, pack(1, 2, 3, 4)});
        recv(0, 1'b1, 0);

        // All-127 operands: clamp vs wrap
        send(0, pack(127, 127, 127, 127), pack(127, 127, 127, 127), {1'b1, pack(127, 127, 127, 127)});
        recv(0, 1'b1, 0);
        send(1, pack(127, 127, 127, 127), pack(127, 127, 127, 127), {1'b1, pack(2, 2, 2, 2)});
        recv(1, 1'b1, 0);

        // Signs, including +128 clamping to 127
        send(0, pack(-1, 0, 0, -1), pack(5, -6, 7, -128), {1'b1, pack(-5, 6, -7, 127)});
        recv(0, 1'b0, 0);

        // Fractional scaling and floor behaviour
        send(2, pack(16, 0, 0, 16), pack(3, -3, 1, 0), {1'b0, pack(3, -3, 1, 0)});
        recv(2, 1'b1, 0);
        send(2, pack(1, 0, 0, 1), pack(-1, 5, 7, -20), {1'b0, pack(-1, 0, 0, -2)});
        recv(2, 1'b0, 0);

        // Backpressure: result held for 5 cycles with m_ready low
        send(0, pack(2, -3, 4, 5), pack(-7, 6, 1, 9), model(pack(2, -3, 4, 5), pack(-7, 6, 1, 9), 0, 1'b1));
        recv(0, 1'b0, 5);

        // Back-to-back random pairs on every instance
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 6; n++) begin
                a = $urandom();
                b = $urandom();
                if (n == 0) a = pack($urandom_range(0, 255), 0, 0, $urandom_range(0, 255));
                send(d, a, b, model(a, b, frac_of(d), sat_of(d)));
                recv(d, 1'b1, (n == 3) ? 2 : 0);
            end
        end

        // Reset during the first COMPUTE cycle abandons the pair
        send(0, pack(9, 9, 9, 9), pack(9, 9, 9, 9), model(pack(9, 9, 9, 9), pack(9, 9, 9, 9), 0, 1'b1));
        void'(exp_q.pop_back());
        rst = 1'b1;
        #1;
        check("mid_rst_s_ready", 64'(s_ready[0]), 64'd0);
        @(negedge clk);
        check("mid_rst_state", 64'(dbg[0]), 64'd0);
        check("mid_rst_m_valid", 64'(m_valid[0]), 64'd0);
        check("mid_rst_c_flat", 64'(c_flat[0]), 64'd0);
        check("mid_rst_ovf", 64'(ovf[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("after_rst_s_ready", 64'(s_ready[0]), 64'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abandoned_no_m_valid", 64'(m_valid[0]), 64'd0);
        end
        send(0, pack(3, 1, -2, 4), pack(5, -1, 2, 6), {1'b0, pack(17, 3, -2, 26)});
        recv(0, 1'b1, 0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
